// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller.
//   - op_e     : operation encodings presented on the op port
//   - state_e  : controller FSM states
//   - A_*      : ALU operation codes understood by muldiv_ctrl_alu
//   - ITER_*   : iteration count of the shift-add / restoring-divide loop
//   - abs32, neg32, neg64 : two's-complement helpers used in PREP and FIXUP
package muldiv_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_ITER  = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [3:0] A_AND  = 4'b0000;
    localparam logic [3:0] A_OR   = 4'b0001;
    localparam logic [3:0] A_ADD  = 4'b0010;
    localparam logic [3:0] A_ADDU = 4'b0011;
    localparam logic [3:0] A_SUBU = 4'b0100;
    localparam logic [3:0] A_SUB  = 4'b0101;
    localparam logic [3:0] A_SLT  = 4'b0110;
    localparam logic [3:0] A_SLTU = 4'b0111;
    localparam logic [3:0] A_XOR  = 4'b1000;
    localparam logic [3:0] A_NOR  = 4'b1001;
    localparam logic [3:0] A_SLL  = 4'b1010;
    localparam logic [3:0] A_SRL  = 4'b1011;

    localparam int         ITER_COUNT = 32;
    localparam logic [4:0] ITER_LAST  = 5'(ITER_COUNT - 1);

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

    // 0x80000000 negates to itself, which read as unsigned is the correct magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? neg32(x) : x;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_alu.sv
// Existing 32-bit integer ALU, reused by the multiply/divide controller.
// Ports:
//   alu_a, alu_b  in  32  operands
//   alu_op        in  4   operation (A_* codes from muldiv_ctrl_pkg)
//   shamt         in  5   shift amount for A_SLL / A_SRL (shifts alu_b)
//   alu_result    out 32  result
//   alu_overflow  out 1   signed overflow for A_ADD / A_SUB
module muldiv_ctrl_alu
    import muldiv_ctrl_pkg::*;
(
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [3:0]  alu_op,
    input  logic [4:0]  shamt,
    output logic [31:0] alu_result,
    output logic        alu_overflow
);

    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = alu_a + alu_b;
    assign diff = alu_a - alu_b;

    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (alu_op)
            A_AND:  alu_result = alu_a & alu_b;
            A_OR:   alu_result = alu_a | alu_b;
            A_ADD: begin
                alu_result   = sum;
                alu_overflow = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
            end
            A_ADDU: alu_result = sum;
            A_SUBU: alu_result = diff;
            A_SUB: begin
                alu_result   = diff;
                alu_overflow = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
            end
            A_SLT:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            A_SLTU: alu_result = {31'd0, alu_a < alu_b};
            A_XOR:  alu_result = alu_a ^ alu_b;
            A_NOR:  alu_result = ~(alu_a | alu_b);
            A_SLL:  alu_result = alu_b << shamt;
            A_SRL:  alu_result = alu_b >> shamt;
            default: alu_result = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MIPS-style multiply/divide unit with architectural HI/LO registers.
// Signed operands are converted to magnitudes in PREP, 32 single-bit iterations
// (shift-add multiply or restoring divide) run in ITER, and FIXUP restores signs
// and writes HI/LO on the edge into DONE.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start, op         operation request (sampled only in IDLE) and opcode
//   src_a, src_b      multiplicand/dividend and multiplier/divisor
//   hi_we, lo_we      MTHI/MTLO strobes, data on wdata (honoured only in IDLE)
//   busy, done        busy outside IDLE; done is a one-cycle pulse in DONE
//   div_by_zero       qualifies done for a divide with a zero divisor
//   hi, lo            architectural HI/LO registers
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e      state_q;
    op_e         op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] opd_q;      // multiplicand (mult) or divisor (div), as magnitude
    logic [31:0] acc_q;      // running product high half / partial remainder
    logic [31:0] lsr_q;      // multiplier shifting out / quotient shifting in
    logic [4:0]  cnt_q;
    logic        neg_res_q;  // product or quotient must be negated in FIXUP
    logic        neg_rem_q;  // remainder must be negated in FIXUP
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;
    logic        dbz_q;

    logic        is_div;
    logic        is_signed;
    logic [31:0] a_abs;
    logic [31:0] b_abs;

    logic [3:0]  alu_op_sel;
    logic [31:0] alu_a;
    logic [31:0] alu_result;
    logic        alu_overflow_unused;

    logic [31:0] trial;      // low 32 bits of the left-shifted partial remainder
    logic        rem_msb;    // 33rd bit of the shifted partial remainder
    logic        carry;
    logic        fits;
    logic [31:0] acc_d;
    logic [31:0] lsr_d;

    assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
    assign a_abs     = is_signed ? abs32(a_q) : a_q;
    assign b_abs     = is_signed ? abs32(b_q) : b_q;

    // One ALU serves both loops: add multiplicand, or trial-subtract divisor.
    assign trial      = {acc_q[30:0], lsr_q[31]};
    assign rem_msb    = acc_q[31];
    assign alu_op_sel = is_div ? A_SUBU : A_ADDU;
    assign alu_a      = is_div ? trial : acc_q;

    muldiv_ctrl_alu u_alu (
        .alu_a        (alu_a),
        .alu_b        (opd_q),
        .alu_op       (alu_op_sel),
        .shamt        (5'd0),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow_unused)
    );

    // An unsigned add carried out exactly when the sum wrapped below an operand.
    assign carry = alu_result < acc_q;
    // Subtraction succeeds if the shifted remainder overflowed 32 bits or has no borrow.
    assign fits  = rem_msb | (trial >= opd_q);

    always_comb begin
        acc_d = acc_q;
        lsr_d = lsr_q;
        if (is_div) begin
            acc_d = fits ? alu_result : trial;
            lsr_d = {lsr_q[30:0], fits};
        end else if (lsr_q[0]) begin
            acc_d = {carry, alu_result[31:1]};
            lsr_d = {alu_result[0], lsr_q[31:1]};
        end else begin
            acc_d = {1'b0, acc_q[31:1]};
            lsr_d = {acc_q[0], lsr_q[31:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= OP_MULT;
            a_q       <= '0;
            b_q       <= '0;
            opd_q     <= '0;
            acc_q     <= '0;
            lsr_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        // A simultaneous MTHI/MTLO is dropped in favour of the operation.
                        op_q    <= op_e'(op);
                        a_q     <= src_a;
                        b_q     <= src_b;
                        busy_q  <= 1'b1;
                        state_q <= S_PREP;
                    end else begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                S_PREP: begin
                    neg_res_q <= is_signed & (a_q[31] ^ b_q[31]);
                    neg_rem_q <= is_signed & a_q[31];
                    cnt_q     <= '0;
                    if (is_div && (b_q == 32'd0)) begin
                        done_q  <= 1'b1;
                        dbz_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        opd_q   <= is_div ? b_abs : a_abs;
                        lsr_q   <= is_div ? a_abs : b_abs;
                        acc_q   <= '0;
                        state_q <= S_ITER;
                    end
                end
                S_ITER: begin
                    acc_q <= acc_d;
                    lsr_q <= lsr_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == ITER_LAST) state_q <= S_FIXUP;
                end
                S_FIXUP: begin
                    if (is_div) begin
                        lo_q <= neg_res_q ? neg32(lsr_q) : lsr_q;
                        hi_q <= neg_rem_q ? neg32(acc_q) : acc_q;
                    end else if (neg_res_q) begin
                        {hi_q, lo_q} <= neg64({acc_q, lsr_q});
                    end else begin
                        {hi_q, lo_q} <= {acc_q, lsr_q};
                    end
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
        int          id;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   next_id = 0;

    muldiv_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", name, act);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pending operation", cyc);
            end else begin
                mon_e = sb.pop_front();
                $display("[TB] done op#%0d cycle %0d hi=%h lo=%h dbz=%0b", mon_e.id, cyc, hi, lo, div_by_zero);
                check($sformatf("op%0d_hi", mon_e.id), {32'd0, hi}, {32'd0, mon_e.hi});
                check($sformatf("op%0d_lo", mon_e.id), {32'd0, lo}, {32'd0, mon_e.lo});
                check($sformatf("op%0d_dbz", mon_e.id), {63'd0, div_by_zero}, {63'd0, mon_e.dbz});
                check($sformatf("op%0d_done_cycle", mon_e.id), 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    // Start an operation in the current cycle 0 and queue its expected result.
    // The operand inputs are scrambled afterwards: the result must not depend on them.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic ed,
                          input int lat, input logic hw);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        hi_we = hw;
        wdata = hw ? 32'h0000AAAA : 32'd0;
        e.hi  = eh;
        e.lo  = el;
        e.dbz = ed;
        e.cyc = cyc + lat;
        e.id  = next_id;
        next_id++;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        op    = 2'($urandom);
        src_a = $urandom;
        src_b = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(sb.size() == 0 && busy === 1'b0) && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (n >= 80) begin
            tests++;
            fails++;
            $display("FAIL timeout: got %0d pending results after 80 cycles, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed, input int lat);
        launch(o, a, b, eh, el, ed, lat, 1'b0);
        wait_idle();
    endtask

    initial begin
        int bad;
        int c0;
        rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

        // Reset state, with start and write strobes asserted to show reset priority.
        repeat (2) @(negedge clk);
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        rst = 1'b0;

        // MULTU max*max with busy window over cycles 1..35.
        launch(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 35, 1'b0);
        bad = 0;
        for (int k = 1; k <= 35; k++) begin
            if (busy !== 1'b1) bad++;
            if (k < 35) @(negedge clk);
        end
        check("busy_cycles_1_35_low_count", 64'(bad), 64'd0);
        @(negedge clk);
        check("busy_cycle_36", {63'd0, busy}, 64'd0);
        wait_idle();

        run(MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 35);
        run(DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35);
        run(DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 35);
        run(DIV,  32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 35);
        run(MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 35);
        run(MULT, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h80000000, 1'b0, 35);
        run(DIVU, 32'hFFFFFFFF, 32'd1, 32'h00000000, 32'hFFFFFFFF, 1'b0, 35);

        // MTLO / MTHI in IDLE, readable next cycle.
        @(negedge clk); lo_we = 1'b1; wdata = 32'h00001234;
        @(negedge clk); lo_we = 1'b0;
        check("mtlo_lo", {32'd0, lo}, 64'h1234);
        hi_we = 1'b1; wdata = 32'h00005678;
        @(negedge clk); hi_we = 1'b0;
        check("mthi_hi", {32'd0, hi}, 64'h5678);

        // Divide by zero: done at cycle 2, hi/lo untouched.
        run(DIVU, 32'd100, 32'd0, 32'h00005678, 32'h00001234, 1'b1, 2);
        run(DIV,  32'd5,   32'd0, 32'h00005678, 32'h00001234, 1'b1, 2);

        // DIVU 100/7 with a same-cycle hi_we (dropped) and a start+hi_we pulse at cycle 5 (ignored).
        launch(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 35, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1; hi_we = 1'b1; wdata = 32'h0000AAAA; op = MULTU;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        check("hi_during_busy", {32'd0, hi}, 64'h5678);
        wait_idle();
        repeat (3) @(negedge clk);
        check("no_queued_op_busy", {63'd0, busy}, 64'd0);

        // Reset in cycle 10 abandons MULTU 0xFFFFFFFF*2; restart in cycle 12 finishes at 47.
        @(negedge clk);
        c0 = cyc;
        start = 1'b1; op = MULTU; src_a = 32'hFFFFFFFF; src_b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_hi", {32'd0, hi}, 64'd0);
        check("midrst_lo", {32'd0, lo}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        launch(MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b0, 35, 1'b0);
        wait_idle();
        check("restart_done_cycle_rel", 64'(cyc - c0 >= 47), 64'd1);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameters: none; data width fixed at 32 bits.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  request an operation; sampled only in IDLE.
REQ-006 op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 src_a  in  32  multiplicand or dividend (rs).
REQ-008 src_b  in  32  multiplier or divisor (rt).
REQ-009 hi_we, lo_we  in  1 each  MTHI/MTLO write strobes.
REQ-010 wdata  in  32  MTHI/MTLO data.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle pulse in DONE.
REQ-013 div_by_zero  out  1  valid only with done; high for DIV/DIVU with src_b==0.
REQ-014 hi, lo  out  32 each  architectural HI/LO registers.

Function
REQ-015 States: IDLE, PREP, ITER, FIXUP, DONE; DONE always returns to IDLE on the next edge.
REQ-016 Cycle 0: IDLE with start=1, so op, src_a and src_b are latched. Cycle 1: PREP. Cycles 2-33: ITER (32 iterations, 5-bit counter). Cycle 34: FIXUP. Cycle 35: DONE.
REQ-017 The hi/lo result is written on the edge entering DONE and is visible in the same cycle as done=1.
REQ-018 PREP, signed ops: latch absolute values of both operands and the result-sign flags; 0x80000000 maps to unsigned 0x80000000.
REQ-019 Multiply: shift-add, one bit per ITER cycle; 64-bit product {hi,lo}.
REQ-020 Divide: restoring, one quotient bit per ITER cycle; quotient goes to lo, remainder to hi.
REQ-021 The 33rd bit of the partial remainder is held locally, outside the ALU.
REQ-022 FIXUP, signed ops:
- MULT: negate the 64-bit product if the operand signs differ.
- DIV: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
- Quotient truncates toward zero.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF shall give lo=0x80000000, hi=0; no flag, no trap.
REQ-024 Divide by zero, detected in PREP: go directly to DONE at cycle 2, div_by_zero=1, hi/lo unchanged.
REQ-025 div_by_zero shall be 0 for multiplies and for nonzero divisors.
REQ-026 start, hi_we and lo_we are ignored while busy=1; no queuing.
REQ-027 In IDLE, hi_we/lo_we write wdata to hi/lo on the edge, and the value is readable the next cycle.
REQ-028 In IDLE, if start and hi_we/lo_we are both asserted, start wins and the write is dropped.
REQ-029 hi and lo shall hold their values in all states except when written per REQ-017 or REQ-027.
REQ-030 The result does not depend on src_a, src_b or op after cycle 0.

Reset
REQ-031 When rst=1 at an edge: state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, iteration counter=0.
REQ-032 rst takes priority over start and over the write strobes.
REQ-033 Reset mid-operation abandons the operation; no done pulse is produced for it.

Structure
REQ-034 Shared package: op encodings, state encodings, ALU op constants (A_ADDU=4'b0011, A_SUBU=4'b0100), iteration count 32.
REQ-035 Exactly one sub-module: the existing ALU, instantiated for the per-iteration add (A_ADDU) and trial subtract (A_SUBU). Its alu_overflow output is unused; shamt is tied to 0.
REQ-036 All other logic (FSM, counter, shift registers, sign fixup) is local; target size is 120-400 lines of RTL.

Verification
REQ-037 MULTU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF, start at cycle 0 -> done at cycle 35, hi=0xFFFFFFFE, lo=0x00000001, busy high in cycles 1-35.
REQ-038 MULT src_a=0xFFFFFFFD (-3), src_b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-039 DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-040 lo_we with wdata=0x1234 in IDLE, then DIVU 100/0 -> done at cycle 2 with div_by_zero=1, lo=0x1234, hi unchanged.
REQ-041 DIVU 100/7 with start and hi_we=1, wdata=0xAAAA pulsed at cycle 5 -> both ignored; lo=14, hi=2 at cycle 35.
REQ-042 MULTU 0xFFFFFFFF*2 with rst=1 at cycle 10 -> cycle 11 shows busy=0, hi=lo=0, and done never pulses; a new start at cycle 12 completes at cycle 47.
